// File: rtl/matmul_apb_slave.sv
// APB register front-end of the matmul accelerator.
// Holds control, operands, flags and result scratchpads.
module matmul_apb_slave #(
  parameter int DATA_WIDTH = 8,
  parameter int BUS_WIDTH  = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MAX_DIM    = BUS_WIDTH / DATA_WIDTH
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 psel_i,
  input  logic                                 penable_i,
  input  logic                                 pwrite_i,
  input  logic [MAX_DIM-1:0]                   pstrb_i,
  input  logic [ADDR_WIDTH-1:0]                paddr_i,
  input  logic [BUS_WIDTH-1:0]                 pwdata_i,
  output logic [BUS_WIDTH-1:0]                 prdata_o,
  output logic                                 pready_o,
  output logic                                 pslverr_o,
  output logic                                 busy_o,
  output logic                                 start_o,
  output logic [15:0]                          ctrl_o,
  output logic [MAX_DIM*BUS_WIDTH-1:0]         opa_o,
  output logic [MAX_DIM*BUS_WIDTH-1:0]         opb_o,
  output logic [MAX_DIM*MAX_DIM*BUS_WIDTH-1:0] sp_rd_o,
  input  logic                                 done_i,
  input  logic [MAX_DIM*MAX_DIM*BUS_WIDTH-1:0] res_i,
  input  logic [BUS_WIDTH-1:0]                 flags_i
);

  localparam int LW = $clog2(MAX_DIM);
  localparam int EW = 2 * LW;
  localparam int NE = MAX_DIM * MAX_DIM;
  localparam logic [15:0] CTRL_MASK = 16'h3F3E;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

  typedef logic [MAX_DIM-1:0][BUS_WIDTH-1:0] line_arr_t;
  typedef logic [NE-1:0][BUS_WIDTH-1:0]      sp_arr_t;

  state_e                 state_q, state_d;
  logic [2:0]             rgn_q, rgn_d;
  logic [LW-1:0]          line_q, line_d;
  logic [BUS_WIDTH-1:0]   wdata_q, wdata_d;
  logic [MAX_DIM-1:0]     strb_q, strb_d;
  logic                   write_q, write_d;
  logic                   err_q, err_d;
  logic [BUS_WIDTH-1:0]   prdata_q, prdata_d;
  logic [15:0]            ctrl_q, ctrl_d;
  line_arr_t              opa_q, opa_d;
  line_arr_t              opb_q, opb_d;
  logic [BUS_WIDTH-1:0]   flags_q, flags_d;
  sp_arr_t [3:0]          sp_q, sp_d;
  logic                   busy_q, busy_d;
  logic                   start_q, start_d;

  logic [2:0]             rgn;
  logic [LW-1:0]          line;
  logic [EW-1:0]          elem;
  logic                   is_ctrl, is_opa, is_opb, is_flag, is_sp;
  logic                   oob, err;
  logic [BUS_WIDTH-1:0]   rdata;
  logic [15:0]            cnew;

  function automatic logic [BUS_WIDTH-1:0] merge(
    input logic [BUS_WIDTH-1:0] o,
    input logic [BUS_WIDTH-1:0] n,
    input logic [MAX_DIM-1:0]   s
  );
    merge = o;
    for (int b = 0; b < MAX_DIM; b++)
      if (s[b])
        merge[b*DATA_WIDTH+:DATA_WIDTH] =
          n[b*DATA_WIDTH+:DATA_WIDTH];
  endfunction

  assign rgn     = paddr_i[4:2];
  assign line    = paddr_i[5+:LW];
  assign elem    = paddr_i[5+:EW];
  assign is_ctrl = rgn == 3'd0;
  assign is_opa  = rgn == 3'd1;
  assign is_opb  = rgn == 3'd2;
  assign is_flag = rgn == 3'd3;
  assign is_sp   = rgn[2];

  // Any address bit above the line/element field is out of range.
  assign oob = ((is_opa | is_opb) & (|paddr_i[ADDR_WIDTH-1:5+LW]))
             | (is_sp & (|paddr_i[ADDR_WIDTH-1:5+EW]));

  assign err = (paddr_i[1:0] != 2'b00) | oob
             | (pwrite_i & (is_flag | is_sp))
             | (pwrite_i & busy_q & (is_ctrl | is_opa | is_opb));

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      is_ctrl: rdata = {{(BUS_WIDTH-16){1'b0}}, ctrl_q};
      is_opa:  rdata = opa_q[line];
      is_opb:  rdata = opb_q[line];
      is_flag: rdata = flags_q;
      default: rdata = sp_q[rgn[1:0]][elem];
    endcase
  end

  always_comb begin
    state_d  = state_q;
    rgn_d    = rgn_q;
    line_d   = line_q;
    wdata_d  = wdata_q;
    strb_d   = strb_q;
    write_d  = write_q;
    err_d    = 1'b0;
    prdata_d = '0;
    ctrl_d   = ctrl_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    flags_d  = flags_q;
    sp_d     = sp_q;
    busy_d   = busy_q;
    start_d  = 1'b0;
    cnew     = ctrl_q;
    unique case (state_q)
      IDLE: begin
        if (psel_i && !penable_i) state_d = SETUP;
      end
      SETUP: begin
        if (!psel_i) begin
          state_d = IDLE;
        end else if (penable_i) begin
          state_d  = ACCESS;
          rgn_d    = rgn;
          line_d   = line;
          wdata_d  = pwdata_i;
          strb_d   = pstrb_i;
          write_d  = pwrite_i;
          err_d    = err;
          prdata_d = (pwrite_i || err) ? '0 : rdata;
        end
      end
      ACCESS: begin
        state_d = IDLE;
        if (write_q && !err_q) begin
          unique case (1'b1)
            rgn_q == 3'd0: begin
              for (int b = 0; b < 16 / DATA_WIDTH; b++)
                if (strb_q[b])
                  cnew[b*DATA_WIDTH+:DATA_WIDTH] =
                    wdata_q[b*DATA_WIDTH+:DATA_WIDTH];
              ctrl_d = cnew & CTRL_MASK;
              if (wdata_q[0] && strb_q[0]) begin
                start_d = 1'b1;
                busy_d  = 1'b1;
              end
            end
            rgn_q == 3'd1:
              opa_d[line_q] = merge(opa_q[line_q], wdata_q, strb_q);
            rgn_q == 3'd2:
              opb_d[line_q] = merge(opb_q[line_q], wdata_q, strb_q);
            default: ;
          endcase
        end
      end
      default: state_d = IDLE;
    endcase
    if (done_i && busy_q) begin
      busy_d             = 1'b0;
      sp_d[ctrl_q[3:2]]  = res_i;
      flags_d            = flags_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      rgn_q    <= '0;
      line_q   <= '0;
      wdata_q  <= '0;
      strb_q   <= '0;
      write_q  <= 1'b0;
      err_q    <= 1'b0;
      prdata_q <= '0;
      ctrl_q   <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      flags_q  <= '0;
      sp_q     <= '0;
      busy_q   <= 1'b0;
      start_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      rgn_q    <= rgn_d;
      line_q   <= line_d;
      wdata_q  <= wdata_d;
      strb_q   <= strb_d;
      write_q  <= write_d;
      err_q    <= err_d;
      prdata_q <= prdata_d;
      ctrl_q   <= ctrl_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      flags_q  <= flags_d;
      sp_q     <= sp_d;
      busy_q   <= busy_d;
      start_q  <= start_d;
    end
  end

  assign prdata_o  = prdata_q;
  assign pready_o  = state_q == ACCESS;
  assign pslverr_o = err_q;
  assign busy_o    = busy_q;
  assign start_o   = start_q;
  assign ctrl_o    = ctrl_q;
  assign opa_o     = opa_q;
  assign opb_o     = opb_q;
  assign sp_rd_o   = sp_q[ctrl_q[5:4]];

endmodule

// File: tb/tb_matmul_apb_slave.sv
// Directed bench for matmul_apb_slave.
// Vector table plus hand sequences for start/done/reset corners.
module tb_matmul_apb_slave;

  localparam int BW = 32;
  localparam int MD = 4;

  logic              clk = 1'b0;
  logic              rst_i = 1'b1;
  logic              psel_i = 1'b0;
  logic              penable_i = 1'b0;
  logic              pwrite_i = 1'b0;
  logic [MD-1:0]     pstrb_i = '0;
  logic [31:0]       paddr_i = '0;
  logic [BW-1:0]     pwdata_i = '0;
  logic [BW-1:0]     prdata_o;
  logic              pready_o;
  logic              pslverr_o;
  logic              busy_o;
  logic              start_o;
  logic [15:0]       ctrl_o;
  logic [MD*BW-1:0]  opa_o;
  logic [MD*BW-1:0]  opb_o;
  logic [MD*MD*BW-1:0] sp_rd_o;
  logic              done_i = 1'b0;
  logic [MD*MD*BW-1:0] res_i = '0;
  logic [BW-1:0]     flags_i = '0;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  matmul_apb_slave dut (
    .clk_i(clk), .rst_i(rst_i),
    .psel_i(psel_i), .penable_i(penable_i),
    .pwrite_i(pwrite_i), .pstrb_i(pstrb_i),
    .paddr_i(paddr_i), .pwdata_i(pwdata_i),
    .prdata_o(prdata_o), .pready_o(pready_o),
    .pslverr_o(pslverr_o), .busy_o(busy_o),
    .start_o(start_o), .ctrl_o(ctrl_o),
    .opa_o(opa_o), .opb_o(opb_o),
    .sp_rd_o(sp_rd_o), .done_i(done_i),
    .res_i(res_i), .flags_i(flags_i)
  );

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] rd;
    logic        err;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got 0x%08h expected 0x%08h",
               name, act, exp);
    else
      passed++;
  endtask

  // dcyc: 1 pulses done_i in the setup cycle, 2 in the access cycle
  task automatic apb(input logic wr, input logic [31:0] addr,
                     input logic [31:0] data, input logic [3:0] strb,
                     input int dcyc,
                     output logic [31:0] rd, output logic er);
    logic got;
    @(posedge clk); #1;
    psel_i = 1'b1; penable_i = 1'b0; pwrite_i = wr;
    paddr_i = addr; pwdata_i = data; pstrb_i = strb;
    @(posedge clk); #1;
    penable_i = 1'b1;
    done_i = (dcyc == 1);
    @(posedge clk); #1;
    done_i = (dcyc == 2);
    got = 1'b0; rd = '0; er = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (pready_o) begin
        got = 1'b1; rd = prdata_o; er = pslverr_o;
      end
    end
    if (!got) begin
      total++;
      $display("FAIL pready_timeout: addr 0x%08h got no pready expected pready", addr);
    end
    @(posedge clk); #1;
    psel_i = 1'b0; penable_i = 1'b0; done_i = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    logic        bad;

    vecs[0]  = '{1'b1, 32'h44,  32'h04030201, 4'hF, 32'h0, 1'b0};
    vecs[1]  = '{1'b0, 32'h44,  32'h0,        4'h0, 32'h04030201, 1'b0};
    vecs[2]  = '{1'b1, 32'h44,  32'hFFFFFFFF, 4'h2, 32'h0, 1'b0};
    vecs[3]  = '{1'b0, 32'h44,  32'h0,        4'h0, 32'h0403FF01, 1'b0};
    vecs[4]  = '{1'b1, 32'h28,  32'hDEADBEEF, 4'hF, 32'h0, 1'b0};
    vecs[5]  = '{1'b0, 32'h28,  32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
    vecs[6]  = '{1'b1, 32'h0C,  32'h55,       4'hF, 32'h0, 1'b1};
    vecs[7]  = '{1'b0, 32'h0C,  32'h0,        4'h0, 32'h0, 1'b0};
    vecs[8]  = '{1'b1, 32'h78,  32'h1,        4'hF, 32'h0, 1'b1};
    vecs[9]  = '{1'b0, 32'h78,  32'h0,        4'h0, 32'h0, 1'b0};
    vecs[10] = '{1'b0, 32'h02,  32'h0,        4'h0, 32'h0, 1'b1};
    vecs[11] = '{1'b1, 32'h02,  32'h12345678, 4'hF, 32'h0, 1'b1};
    vecs[12] = '{1'b1, 32'h00,  32'hFFFFFFFE, 4'h3, 32'h0, 1'b0};
    vecs[13] = '{1'b0, 32'h00,  32'h0,        4'h0, 32'h3F3E, 1'b0};
    vecs[14] = '{1'b0, 32'h84,  32'h0,        4'h0, 32'h0, 1'b1};
    vecs[15] = '{1'b0, 32'h1F0, 32'h0,        4'h0, 32'h0, 1'b0};
    vecs[16] = '{1'b1, 32'h00,  32'h0,        4'hF, 32'h0, 1'b0};
    vecs[17] = '{1'b0, 32'h00,  32'h0,        4'h0, 32'h0, 1'b0};

    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    chk("rst_prdata", prdata_o, 0);
    chk("rst_pready", 32'(pready_o), 0);
    chk("rst_pslverr", 32'(pslverr_o), 0);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_start", 32'(start_o), 0);
    chk("rst_ctrl", 32'(ctrl_o), 0);
    chk("rst_ops", 32'(|{opa_o, opb_o, sp_rd_o}), 0);

    // Load some state, then reset in the middle of an access.
    apb(1'b1, 32'h04, 32'h11223344, 4'hF, 0, rd, er);
    apb(1'b1, 32'h00, 32'h00000010, 4'hF, 0, rd, er);
    chk("pre_rst_opa0", opa_o[31:0], 32'h11223344);
    chk("pre_rst_ctrl", 32'(ctrl_o), 32'h10);
    @(posedge clk); #1;
    psel_i = 1'b1; penable_i = 1'b0; pwrite_i = 1'b1;
    paddr_i = 32'h24; pwdata_i = 32'hCAFE0001; pstrb_i = 4'hF;
    @(posedge clk); #1 penable_i = 1'b1;
    @(posedge clk); #1 rst_i = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b0; psel_i = 1'b0; penable_i = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bad |= pready_o;
    end
    chk("mid_rst_pready", 32'(bad), 0);
    chk("mid_rst_ops", 32'(|{opa_o, opb_o}), 0);
    chk("mid_rst_ctrl", 32'(ctrl_o), 0);

    for (int i = 0; i < 18; i++) begin
      apb(vecs[i].wr, vecs[i].addr, vecs[i].data,
          vecs[i].strb, 0, rd, er);
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].rd);
      chk($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].err));
    end
    chk("opa_line2", opa_o[64+:32], 32'h0403FF01);
    chk("opb_line1", opb_o[32+:32], 32'hDEADBEEF);

    // Start pulse, busy behaviour and busy-write errors.
    apb(1'b1, 32'h00, 32'h1525, 4'hF, 0, rd, er);
    chk("start_err", 32'(er), 0);
    @(negedge clk);
    chk("start_pulse", 32'(start_o), 1);
    chk("start_busy", 32'(busy_o), 1);
    @(negedge clk);
    chk("start_once", 32'(start_o), 0);
    apb(1'b0, 32'h00, 32'h0, 4'h0, 0, rd, er);
    chk("ctrl_rb", rd, 32'h1524);
    chk("ctrl_o", 32'(ctrl_o), 32'h1524);
    apb(1'b1, 32'h28, 32'h11111111, 4'hF, 0, rd, er);
    chk("busy_opb_err", 32'(er), 1);
    apb(1'b0, 32'h28, 32'h0, 4'h0, 0, rd, er);
    chk("busy_opb_keep", rd, 32'hDEADBEEF);
    apb(1'b1, 32'h00, 32'h1, 4'hF, 0, rd, er);
    chk("busy_start_err", 32'(er), 1);
    @(negedge clk);
    chk("busy_no_pulse", 32'(start_o), 0);

    // Completion into SP1.
    res_i[6*32+:32] = 32'h12345678;
    res_i[0+:32]    = 32'h000000A5;
    flags_i = 32'h3;
    @(posedge clk); #1 done_i = 1'b1;
    @(posedge clk); #1 done_i = 1'b0;
    @(negedge clk);
    chk("done_busy", 32'(busy_o), 0);
    apb(1'b0, 32'hD4, 32'h0, 4'h0, 0, rd, er);
    chk("sp1_e6", rd, 32'h12345678);
    apb(1'b0, 32'h14, 32'h0, 4'h0, 0, rd, er);
    chk("sp1_e0", rd, 32'hA5);
    apb(1'b0, 32'h0C, 32'h0, 4'h0, 0, rd, er);
    chk("flags", rd, 32'h3);

    // done_i while idle must be ignored.
    res_i[6*32+:32] = 32'h0BADBEEF;
    flags_i = 32'h7;
    @(posedge clk); #1 done_i = 1'b1;
    @(posedge clk); #1 done_i = 1'b0;
    apb(1'b0, 32'hD4, 32'h0, 4'h0, 0, rd, er);
    chk("idle_done_sp", rd, 32'h12345678);
    apb(1'b0, 32'h0C, 32'h0, 4'h0, 0, rd, er);
    chk("idle_done_flags", rd, 32'h3);
    res_i[6*32+:32] = 32'h12345678;
    apb(1'b1, 32'h00, 32'h10, 4'hF, 0, rd, er);
    chk("sp_rd_sel", sp_rd_o[6*32+:32], 32'h12345678);

    // Control write colliding with done_i, then retry.
    apb(1'b1, 32'h00, 32'h1525, 4'hF, 0, rd, er);
    apb(1'b1, 32'h00, 32'h0005, 4'hF, 2, rd, er);
    chk("coll_err", 32'(er), 1);
    @(negedge clk);
    chk("coll_no_start", 32'(start_o), 0);
    chk("coll_idle", 32'(busy_o), 0);
    apb(1'b1, 32'h00, 32'h0005, 4'hF, 0, rd, er);
    chk("retry_err", 32'(er), 0);
    @(negedge clk);
    chk("retry_start", 32'(start_o), 1);

    // Read coinciding with the done update sees the old value.
    res_i[6*32+:32] = 32'hCAFEF00D;
    apb(1'b0, 32'hD4, 32'h0, 4'h0, 1, rd, er);
    chk("sp_pre_update", rd, 32'h12345678);
    apb(1'b0, 32'hD4, 32'h0, 4'h0, 0, rd, er);
    chk("sp_post_update", rd, 32'hCAFEF00D);
    chk("final_busy", 32'(busy_o), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/matmul_apb_slave.md
# matmul_apb_slave

APB responder and register front-end of the matmul accelerator: the block that answers the APB master in the matmul testbench. Decodes APB setup/access phases, holds the control register, operand-A rows, operand-B columns, the flags register and four result scratchpads, and drives the core with a start pulse plus static operands. Sits between the APB bus (matmul_intf) and the matmul compute core.

## Interface
- DATA_WIDTH, 8, operand element width
- BUS_WIDTH, 32, APB data width; also scratchpad element width
- ADDR_WIDTH, 32, APB address width
- MAX_DIM, BUS_WIDTH/DATA_WIDTH (=4), max matrix dimension; operand lines and strobe bits
- clk_i  in  1  clock; all logic on rising edge
- rst_i  in  1  reset; synchronous, active-high
- psel_i, penable_i, pwrite_i  in  1 each  APB controls
- pstrb_i  in  MAX_DIM  byte-lane write strobes
- paddr_i  in  ADDR_WIDTH  address
- pwdata_i  in  BUS_WIDTH  write data
- prdata_o  out  BUS_WIDTH  read data, valid while pready_o=1
- pready_o  out  1  transfer complete
- pslverr_o  out  1  transfer error, valid while pready_o=1
- busy_o  out  1  core running
- start_o  out  1  one-cycle start pulse to core
- ctrl_o  out  16  control register contents
- opa_o  out  MAX_DIM*BUS_WIDTH  operand-A rows, row r at [r*BUS_WIDTH+:BUS_WIDTH]
- opb_o  out  MAX_DIM*BUS_WIDTH  operand-B columns, same packing
- sp_rd_o  out  MAX_DIM*MAX_DIM*BUS_WIDTH  scratchpad selected by ctrl read_target (accumulate source)
- done_i  in  1  core finished (one-cycle pulse)
- res_i  in  MAX_DIM*MAX_DIM*BUS_WIDTH  result matrix, element (i,j) at index i*MAX_DIM+j
- flags_i  in  BUS_WIDTH  core overflow flags

## Operation
- Address decode: region = paddr_i[4:0]; CONTROL 0x00, OPERAND_A 0x04, OPERAND_B 0x08, FLAGS 0x0C, SP0 0x10, SP1 0x14, SP2 0x18, SP3 0x1C. Line = paddr_i[5+:log2(MAX_DIM)] for operands; element = paddr_i[5+:2*log2(MAX_DIM)] for SPn.
- Control layout: [0] start, [1] mode, [3:2] write_target, [5:4] read_target, [9:8] n-1, [11:10] k-1, [13:12] m-1; other bits read 0.
- FSM: IDLE -> SETUP on psel_i&!penable_i; SETUP -> ACCESS on psel_i&penable_i (back to IDLE if psel_i drops); ACCESS: pready_o=1 one cycle, operation committed, -> IDLE.
- Writes: only byte lanes with pstrb_i[b]=1 update. CONTROL/OPERAND_A/OPERAND_B writable when busy_o=0.
- Start: committed CONTROL write with pwdata_i[0]=1 and pstrb_i[0]=1 -> start_o=1 next cycle, busy_o=1 next cycle, stored bit0 cleared (reads 0).
- done_i: busy_o=0 next cycle; res_i copied into SP[write_target]; flags register <= flags_i.
- Reads: any region readable, any time; OPERAND lines return stored row/column.
- pslverr_o=1 (with pready_o, no state change) for: write to CONTROL/OPERAND while busy_o=1; write to FLAGS or SPn; paddr_i[1:0]!=0; line/element index out of range.

## Timing
- Reset values: prdata_o=0, pready_o=0, pslverr_o=0, busy_o=0, start_o=0, ctrl_o=0, opa_o=0, opb_o=0, flags=0, all SP=0; FSM=IDLE.
- Transfer latency: setup cycle + one access cycle with pready_o=1 (zero wait states); prdata_o registered, valid exactly in that cycle, 0 otherwise.
- start_o rises the cycle after the committing ACCESS cycle; busy_o rises same cycle, stays until cycle after done_i.
- done_i in same cycle as CONTROL write: write sees busy_o=1 -> pslverr_o, no start.
- done_i while busy_o=0: ignored (no SP/flags update).
- Start written with bit0=1 while busy: error, no second pulse.
- rst_i mid-transfer: next cycle FSM=IDLE, pready_o=0, partial transfer discarded.
- SP read in same cycle as done_i update returns pre-update value.

## Test plan
- Reset: assert rst_i 2 cycles mid-ACCESS -> all outputs 0, pready_o never pulses after reset.
- Write OPERAND_A line 2 = 0x04030201, strb 1111; read back -> prdata_o=0x04030201, pslverr_o=0; write 0xFFFFFFFF strb 0010 -> readback 0x0403FF01.
- CONTROL write 0x1525 -> start_o one pulse next cycle, busy_o=1, CONTROL readback 0x1524; write OPERAND_B while busy -> pslverr_o=1, data unchanged.
- done_i with write_target=1, res_i element(1,2)=0x12345678, flags_i=0x3 -> busy_o=0 next cycle; read SP1 element 6 -> 0x12345678; FLAGS -> 0x3.
- Write to FLAGS, write to SP2, access at paddr 0x02 -> each pslverr_o=1 with pready_o, no state change.
- CONTROL write coincident with done_i -> pslverr_o=1, no start_o; retry next transfer -> start_o pulses.
